// File: rtl/serial_tx.sv
// ============================================================================
//  Module   : serial_tx
//  Function : Parameterised serial transmitter. It sends a start bit, the data
//             bits LSB first, an optional even-parity bit and a stop bit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_EN    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             send,
    output logic             ready,
    output logic             tx_out,
    output logic             done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] idx_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic             tx_next;
    logic             bit_end;
    logic             accept;

    assign bit_end = (bit_cnt == CNT_LAST);
    assign accept  = send && (state == IDLE);

    // State register; tx_out is registered from the decoded next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_out  <= 1'b1;
        end else begin
            state   <= next_state;
            bit_cnt <= cnt_next;
            bit_idx <= idx_next;
            shreg   <= shreg_next;
            tx_out  <= tx_next;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = bit_cnt;
        idx_next   = bit_idx;
        shreg_next = shreg;
        if (state != IDLE) begin
            cnt_next = bit_end ? '0 : bit_cnt + CNT_W'(1);
        end
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = START;
                    shreg_next = data_in;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_LAST) begin
                        idx_next   = '0;
                        next_state = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        ready   = (state == IDLE);
        done    = (state == STOP) && bit_end;
        tx_next = 1'b1;
        case (next_state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[idx_next];
            PARITY:  tx_next = ^shreg;
            default: tx_next = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_tx.sv
// ============================================================================
//  Module   : tb_serial_tx
//  Function : Directed testbench for serial_tx (WIDTH=8, CLKS_PER_BIT=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       send = 1'b0;
    logic       send0 = 1'b0;
    logic       ready, tx_out, done;
    logic       ready0, tx_out0, done0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .send(send),
        .ready(ready), .tx_out(tx_out), .done(done)
    );

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut_np (
        .clk(clk), .reset(reset), .data_in(data_in), .send(send0),
        .ready(ready0), .tx_out(tx_out0), .done(done0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Samples a frame starting just after the accept edge (k=0) until ready
    // returns; bit j is taken from the middle of its bit-time.
    task automatic capture(input bit sel, output logic [15:0] bits, output int len,
                           output int done_cnt, output int done_at, output int unstable);
        logic tx, rdy, dn, prev;
        bits = '0; len = 999; done_cnt = 0; done_at = -1; unstable = 0; prev = 1'b1;
        for (int k = 0; k < 120; k++) begin
            tx  = sel ? tx_out0 : tx_out;
            rdy = sel ? ready0  : ready;
            dn  = sel ? done0   : done;
            if (rdy) begin
                len = k;
                break;
            end
            if (dn) begin
                done_cnt++;
                done_at = k;
            end
            if ((k % 4) == 2 && (k / 4) < 16) bits[k/4] = tx;
            if ((k % 4) != 0 && tx !== prev) unstable++;
            prev = tx;
            step();
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        total++;
        if (tx_out !== 1'b1 || ready !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: tx=%b ready=%b done=%b required 1 1 0", tx_out, ready, done);
        end
        total++;
        if (tx_out0 !== 1'b1 || ready0 !== 1'b1 || done0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_state_np: tx=%b ready=%b done=%b required 1 1 0", tx_out0, ready0, done0);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_frame_a5();
        logic [15:0] bits; int len, dc, da, un;
        data_in = 8'hA5; send = 1'b1;
        step();
        send = 1'b0;
        capture(1'b0, bits, len, dc, da, un);
        total++;
        if (bits[10:0] !== {1'b1, 1'b0, 8'hA5, 1'b0}) begin
            bad++;
            $display("FAIL a5_bits: got %b required %b", bits[10:0], {1'b1, 1'b0, 8'hA5, 1'b0});
        end
        total++;
        if (len !== 44) begin bad++; $display("FAIL a5_len: got %0d required 44", len); end
        total++;
        if (dc !== 1 || da !== 43) begin
            bad++;
            $display("FAIL a5_done: count=%0d at=%0d required count=1 at=43", dc, da);
        end
        total++;
        if (un !== 0) begin bad++; $display("FAIL a5_bit_hold: changes=%0d required 0", un); end
        total++;
        if (tx_out !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL a5_idle_after: tx=%b done=%b required 1 0", tx_out, done);
        end
    endtask

    task automatic test_parity_07();
        logic [15:0] bits; int len, dc, da, un;
        data_in = 8'h07; send = 1'b1;
        step();
        send = 1'b0;
        capture(1'b0, bits, len, dc, da, un);
        total++;
        if (bits[10:0] !== {1'b1, 1'b1, 8'h07, 1'b0} || len !== 44) begin
            bad++;
            $display("FAIL p1_07: bits=%b len=%0d required %b len=44", bits[10:0], len, {1'b1, 1'b1, 8'h07, 1'b0});
        end
        step();
        send0 = 1'b1;
        step();
        send0 = 1'b0;
        capture(1'b1, bits, len, dc, da, un);
        total++;
        if (bits[9:0] !== {1'b1, 8'h07, 1'b0}) begin
            bad++;
            $display("FAIL p0_07_bits: got %b required %b", bits[9:0], {1'b1, 8'h07, 1'b0});
        end
        total++;
        if (len !== 40 || dc !== 1 || da !== 39) begin
            bad++;
            $display("FAIL p0_07_len: len=%0d done_cnt=%0d done_at=%0d required 40 1 39", len, dc, da);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits; int len, dc, da, un;
        data_in = 8'h3C; send = 1'b1;
        step();
        data_in = 8'hC3;
        capture(1'b0, bits, len, dc, da, un);
        total++;
        if (bits[10:0] !== {1'b1, 1'b0, 8'h3C, 1'b0} || len !== 44 || dc !== 1) begin
            bad++;
            $display("FAIL b2b_first: bits=%b len=%0d done=%0d required %b 44 1", bits[10:0], len, dc, {1'b1, 1'b0, 8'h3C, 1'b0});
        end
        total++;
        if (tx_out !== 1'b1) begin bad++; $display("FAIL b2b_gap: tx=%b required 1", tx_out); end
        step();
        send = 1'b0;
        total++;
        if (tx_out !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second_start: tx=%b ready=%b required 0 0", tx_out, ready);
        end
        capture(1'b0, bits, len, dc, da, un);
        total++;
        if (bits[10:0] !== {1'b1, 1'b0, 8'hC3, 1'b0} || len !== 44 || dc !== 1) begin
            bad++;
            $display("FAIL b2b_second: bits=%b len=%0d done=%0d required %b 44 1", bits[10:0], len, dc, {1'b1, 1'b0, 8'hC3, 1'b0});
        end
    endtask

    task automatic test_data_toggle();
        logic [15:0] bits; int len, dc, da, un;
        step();
        data_in = 8'h5A; send = 1'b1;
        step();
        send = 1'b0;
        fork
            capture(1'b0, bits, len, dc, da, un);
            begin
                repeat (50) begin
                    data_in = ~data_in;
                    step();
                end
            end
        join
        total++;
        if (bits[10:0] !== {1'b1, 1'b0, 8'h5A, 1'b0} || len !== 44) begin
            bad++;
            $display("FAIL toggle_5a: bits=%b len=%0d required %b 44", bits[10:0], len, {1'b1, 1'b0, 8'h5A, 1'b0});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] bits; int len, dc, da, un;
        int dn = 0;
        step();
        data_in = 8'h00; send = 1'b1;
        step();
        send = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) dn++;
            step();
        end
        total++;
        if (tx_out !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL midreset_pre: tx=%b ready=%b required 0 0", tx_out, ready);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (tx_out !== 1'b1 || ready !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_abort: tx=%b ready=%b done=%b required 1 1 0", tx_out, ready, done);
        end
        for (int k = 0; k < 30; k++) begin
            if (done || tx_out !== 1'b1) dn++;
            step();
        end
        total++;
        if (dn !== 0) begin bad++; $display("FAIL midreset_quiet: events=%0d required 0", dn); end
        data_in = 8'hA5; send = 1'b1;
        step();
        send = 1'b0;
        capture(1'b0, bits, len, dc, da, un);
        total++;
        if (bits[10:0] !== {1'b1, 1'b0, 8'hA5, 1'b0} || len !== 44 || dc !== 1) begin
            bad++;
            $display("FAIL midreset_resend: bits=%b len=%0d done=%0d required %b 44 1", bits[10:0], len, dc, {1'b1, 1'b0, 8'hA5, 1'b0});
        end
    endtask

    task automatic test_reset_vs_send();
        int ev = 0;
        step();
        data_in = 8'h00; send = 1'b1; reset = 1'b1;
        step();
        send = 1'b0; reset = 1'b0;
        total++;
        if (tx_out !== 1'b1 || ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_priority: tx=%b ready=%b required 1 1", tx_out, ready);
        end
        for (int k = 0; k < 12; k++) begin
            if (tx_out !== 1'b1 || ready !== 1'b1) ev++;
            step();
        end
        total++;
        if (ev !== 0) begin bad++; $display("FAIL reset_priority_idle: events=%0d required 0", ev); end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_parity_07();
        test_back_to_back();
        test_data_toggle();
        test_reset_mid_frame();
        test_reset_vs_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits per frame.
REQ-002 Parameter: CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range is 2 or more.
REQ-003 Parameter: PARITY_EN, default 1; 1 inserts an even-parity bit, 0 omits it.
REQ-004 Port: clk, input, 1 bit, sole clock; all state changes on its rising edge.
REQ-005 Port: reset, input, 1 bit, synchronous, active-high reset.
REQ-006 Port: data_in, input, WIDTH bits, parallel word to transmit; sampled only on accept.
REQ-007 Port: send, input, 1 bit, request to transmit data_in.
REQ-008 Port: ready, output, 1 bit, high when the block can accept a word.
REQ-009 Port: tx_out, output, 1 bit, serial line; idles high.
REQ-010 Port: done, output, 1 bit, one-cycle pulse at the end of each frame.

Function
REQ-011 The block SHALL be a state machine with states IDLE, START, DATA, PARITY and STOP.
REQ-012 Accept is send && ready on a rising edge; on accept, the block SHALL latch data_in into an internal shift register, go to START, and clear its bit-cycle and bit-index counters.
REQ-013 ready SHALL be 1 only in IDLE and is a registered-state decode; send while ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-014 tx_out SHALL be driven from a register: 1 in IDLE, 0 in START, the current data bit in DATA, even parity (XOR of the latched word) in PARITY, and 1 in STOP.
REQ-015 tx_out SHALL change in the cycle after the accept edge.
REQ-016 Each of START, DATA (per bit), PARITY and STOP SHALL hold tx_out for exactly CLKS_PER_BIT cycles.
REQ-017 The bit-cycle counter SHALL be $clog2(CLKS_PER_BIT)+1 bits wide, count 0 to CLKS_PER_BIT-1, and wrap to 0 at each bit boundary.
REQ-018 DATA SHALL send the word LSB first, WIDTH bits in total; the bit index SHALL run from 0 to WIDTH-1.
REQ-019 After the last data bit, the block SHALL go to PARITY when PARITY_EN=1, otherwise directly to STOP.
REQ-020 done SHALL be 1 during the last clock cycle of STOP and 0 at all other times; the following cycle SHALL be IDLE with ready=1.
REQ-021 Frame length from accept to ready=1 SHALL be (WIDTH+2+PARITY_EN) x CLKS_PER_BIT cycles.
REQ-022 Back-to-back frames: send held high SHALL be accepted in the first IDLE cycle, giving exactly one idle-high bit-time of CLKS_PER_BIT... REQ-022 is corrected below.
REQ-022 Back-to-back frames: send held high SHALL be accepted in the first IDLE cycle, giving exactly one clock cycle of tx_out=1 between the STOP bit and the next START bit.
REQ-023 Changes on data_in after accept SHALL NOT affect the frame in progress.

Reset
REQ-024 When reset is asserted, the block SHALL go to IDLE with tx_out=1, ready=1, done=0, and counters and shift register cleared, on the next rising edge.
REQ-025 reset asserted mid-frame SHALL abort the frame with no done pulse; tx_out SHALL return high on that edge.
REQ-026 reset SHALL take priority over send in the same cycle; the word is not accepted.

Verification (bench: WIDTH=8, CLKS_PER_BIT=4)
REQ-027 PARITY_EN=1, send data_in=8'hA5 for one cycle: tx_out = 0, 1,0,1,0,0,1,0,1, 0 (parity), 1, each held 4 cycles; done pulses once at cycle 44; ready is low for 44 cycles.
REQ-028 PARITY_EN=1, data_in=8'h07: parity bit is 1; PARITY_EN=0 with data_in=8'h07: no parity bit, frame is 40 cycles.
REQ-029 send held high with data_in=8'h3C then 8'hC3: two complete frames; the START bit of the second frame begins exactly 1 cycle after done; the second frame carries 8'hC3.
REQ-030 data_in toggled every cycle after accepting 8'h5A: the serialized bits still equal 8'h5A.
REQ-031 reset pulsed at cycle 20 of a frame: tx_out=1 and ready=1 on the next edge, no done pulse, and a new send is accepted normally afterwards.
REQ-032 send asserted together with reset: no frame starts and tx_out stays 1.
